// File: rtl/fetch_unit.sv
// Single-issue, non-prefetching instruction fetch stage: holds the PC, fetches one
// word over a ready handshake, and presents it to the control unit until released.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        Jump,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4, branchOffset, branchTarget, jumpTarget, nextPc;

  // Next-PC candidates; jump outranks a taken branch.
  always_comb begin
    pcPlus4      = pc_q + 32'd4;
    branchOffset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branchTarget = pcPlus4 + branchOffset;
    jumpTarget   = {pcPlus4[31:28], instr_q[25:0], 2'b00};
    if (Jump)       nextPc = jumpTarget;
    else if (PCSrc) nextPc = branchTarget;
    else            nextPc = pcPlus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_d    = {nextPc[31:2], 2'b00};
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= ResetPcAligned;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pcPlus4;
  assign instr       = instr_q;
  assign Opcode      = instr_q[31:26];
  assign Funct       = instr_q[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: each record describes one fetched instruction,
// its memory wait states, stall cycles, and control inputs; a queue tracks expected EXEC contents.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic        Jump;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .Jump(Jump),
    .instr(instr), .instr_valid(instr_valid),
    .Opcode(Opcode), .Funct(Funct),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    int          stalls;
    logic        pcsrc;
    logic        jump;
    logic [31:0] expNext;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one table record from the FETCH cycle through the release of its EXEC phase.
  task automatic applyStimulus(input vec_t v, input logic [31:0] expPc);
    exp_t e;
    logic [31:0] heldInstr;
    checkOutput("fetch_req", {31'b0, imem_req}, 32'd1);
    checkOutput("fetch_addr", imem_addr, expPc);
    checkOutput("fetch_valid", {31'b0, instr_valid}, 32'd0);
    for (int w = 0; w < v.waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      PCSrc      = 1'($urandom_range(1, 0));
      Jump       = 1'($urandom_range(1, 0));
      stepCycle();
      checkOutput("wait_req", {31'b0, imem_req}, 32'd1);
      checkOutput("wait_addr", imem_addr, expPc);
      checkOutput("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = v.rdata;
    PCSrc      = 1'b0;
    Jump       = 1'b0;
    sbq.push_back('{pc: expPc, instr: v.rdata});
    stepCycle();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (sbq.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    checkOutput("exec_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("exec_req", {31'b0, imem_req}, 32'd0);
    checkOutput("exec_instr", instr, e.instr);
    checkOutput("exec_pc", pc, e.pc);
    checkOutput("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
    checkOutput("exec_opcode", {26'b0, Opcode}, {26'b0, e.instr[31:26]});
    checkOutput("exec_funct", {26'b0, Funct}, {26'b0, e.instr[5:0]});
    heldInstr = instr;
    for (int s = 0; s < v.stalls; s++) begin
      stall      = 1'b1;
      PCSrc      = (s % 2 == 0);
      Jump       = 1'($urandom_range(1, 0));
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      stepCycle();
      checkOutput("stall_valid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stall_pc", pc, e.pc);
      checkOutput("stall_instr", instr, heldInstr);
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    PCSrc      = v.pcsrc;
    Jump       = v.jump;
    stepCycle();
    PCSrc = 1'b0;
    Jump  = 1'b0;
    checkOutput("next_addr", imem_addr, v.expNext);
  endtask

  initial begin
    logic [31:0] expPc;
    int          budget;
    // rdata, waits, stalls, PCSrc, Jump, expected next PC
    vecs[0]  = '{32'h8C08_0004, 0, 0, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0000, 3, 0, 1'b0, 1'b0, 32'h0000_0008};
    vecs[2]  = '{32'h1000_0001, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFC, 1, 0, 1'b1, 1'b0, 32'h0000_0004};
    vecs[4]  = '{32'h1000_0002, 0, 0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[5]  = '{32'h1000_FFFC, 0, 2, 1'b0, 1'b0, 32'h0000_0014};
    vecs[6]  = '{32'h1000_FFF9, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFC};
    vecs[7]  = '{32'h0000_0020, 2, 0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[8]  = '{32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 32'h0FFF_FFFC};
    vecs[9]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h1000_0000};
    vecs[10] = '{32'h0800_0040, 0, 0, 1'b1, 1'b1, 32'h1000_0100};
    vecs[11] = '{32'h1000_FFFF, 0, 1, 1'b0, 1'b0, 32'h1000_0104};

    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_opcode", {26'b0, Opcode}, 32'd0);
    checkOutput("rst_funct", {26'b0, Funct}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);

    rst = 1'b0;
    stepCycle();
    budget = 0;
    while (!imem_req && budget < 20) begin
      stepCycle();
      budget++;
    end
    checkOutput("first_req_cycle", budget, 0);

    expPc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], expPc);
      expPc = vecs[i].expNext;
    end

    // Reset arriving together with a memory response must discard it.
    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    stepCycle();
    checkOutput("midrst_instr", instr, 32'h0);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_pc", pc, 32'h0);
    rst = 1'b0;
    stepCycle();
    checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
    checkOutput("post_rst_ignored_ready", {31'b0, instr_valid}, 32'd0);
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
